// File: rtl/peripheral_msi_arbiter_wb_if.sv
// Wishbone bundle between the requesting masters, the round-robin arbiter
// and the shared downstream port. The arbiter takes the slave view; whatever
// drives the masters and models the downstream slave takes the master view.
interface peripheral_msi_arbiter_wb_if #(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int NUM_MASTERS = 2
);
   logic [NUM_MASTERS-1:0][AW-1:0] wbm_adr_i;
   logic [NUM_MASTERS-1:0][DW-1:0] wbm_dat_i;
   logic [NUM_MASTERS-1:0][3:0]    wbm_sel_i;
   logic [NUM_MASTERS-1:0]         wbm_we_i;
   logic [NUM_MASTERS-1:0]         wbm_cyc_i;
   logic [NUM_MASTERS-1:0]         wbm_stb_i;
   logic [NUM_MASTERS-1:0][2:0]    wbm_cti_i;
   logic [NUM_MASTERS-1:0][1:0]    wbm_bte_i;
   logic [NUM_MASTERS-1:0][DW-1:0] wbm_dat_o;
   logic [NUM_MASTERS-1:0]         wbm_ack_o;
   logic [NUM_MASTERS-1:0]         wbm_err_o;
   logic [NUM_MASTERS-1:0]         wbm_rty_o;

   logic [AW-1:0]                  wbs_adr_o;
   logic [DW-1:0]                  wbs_dat_o;
   logic [3:0]                     wbs_sel_o;
   logic                           wbs_we_o;
   logic                           wbs_cyc_o;
   logic                           wbs_stb_o;
   logic [2:0]                     wbs_cti_o;
   logic [1:0]                     wbs_bte_o;
   logic [DW-1:0]                  wbs_dat_i;
   logic                           wbs_ack_i;
   logic                           wbs_err_i;
   logic                           wbs_rty_i;

   logic [NUM_MASTERS-1:0]         grant_o;

   modport slave (
      input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
      input  wbm_cti_i, wbm_bte_i,
      output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
      output wbs_cti_o, wbs_bte_o,
      input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
      output grant_o
   );

   modport master (
      output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
      output wbm_cti_i, wbm_bte_i,
      input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
      input  wbs_cti_o, wbs_bte_o,
      output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
      input  grant_o
   );
endinterface

// File: rtl/peripheral_msi_arbiter_wb.sv
// Round-robin Wishbone arbiter feeding the MSI address-decode mux.
// Ownership spans the whole cyc envelope so bursts and RMW sequences stay
// atomic; a per-transfer watchdog turns a stalled strobe into an error.
// The interface instance must be built with the same DW/AW/NUM_MASTERS.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no owner, grant all zero, downstream bus driven to zero
//   S_OWNED | master 'last' owns the bus until it drops its cyc
module peripheral_msi_arbiter_wb #(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   peripheral_msi_arbiter_wb_if.slave  bus
);
   localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   state_t                 state;
   logic [NUM_MASTERS-1:0] grant;
   logic [LW-1:0]          last;
   logic                   tout;

   logic [LW-1:0]          pick;
   logic [NUM_MASTERS-1:0] pick_oh;
   logic                   any_req;
   logic                   owned;
   logic                   owner_cyc;
   logic                   slv_resp;

   logic [AW-1:0]          fwd_adr;
   logic [DW-1:0]          fwd_dat;
   logic [3:0]             fwd_sel;
   logic                   fwd_we;
   logic                   fwd_cyc;
   logic                   fwd_stb;
   logic [2:0]             fwd_cti;
   logic [1:0]             fwd_bte;

   assign any_req   = |bus.wbm_cyc_i;
   assign owned     = (state == S_OWNED);
   assign owner_cyc = bus.wbm_cyc_i[last];
   assign slv_resp  = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

   // Next owner: first active cyc scanning last+1, last+2, ... with wrap.
   always_comb begin
      int  idx;
      logic found;
      logic [LW-1:0] cand;
      pick  = last;
      found = 1'b0;
      idx   = 0;
      cand  = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = int'(last) + i;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         cand = LW'(idx);
         if (!found && bus.wbm_cyc_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      pick_oh       = '0;
      pick_oh[pick] = 1'b1;
   end

   // Ownership FSM: grant is held while the owner's cyc stays high.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= S_IDLE;
         grant <= '0;
         last  <= LW'(NUM_MASTERS - 1);
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  state <= S_OWNED;
                  grant <= pick_oh;
                  last  <= pick;
               end
            end
            S_OWNED: begin
               if (!owner_cyc) begin
                  if (any_req) begin
                     grant <= pick_oh;
                     last  <= pick;
                  end else begin
                     state <= S_IDLE;
                     grant <= '0;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

   // Watchdog: counts unanswered strobe cycles and pulses tout for one cycle.
   // A response in the final cycle clears the count first, so it wins.
   generate
      if (TIMEOUT > 0) begin : g_wd
         localparam int CW = $clog2(TIMEOUT + 1);
         logic [CW-1:0] wd_cnt;

         // tout is raised on the edge that would bring the count to TIMEOUT.
         always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
               wd_cnt <= '0;
               tout   <= 1'b0;
            end else begin
               tout <= 1'b0;
               if (!fwd_stb || slv_resp) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                  wd_cnt <= '0;
                  tout   <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
            end
         end
      end else begin : g_no_wd
         assign tout = 1'b0;
      end
   endgenerate

   // Downstream bus mirrors the owner; the timeout cycle blanks cyc/stb.
   always_comb begin
      fwd_adr = '0;
      fwd_dat = '0;
      fwd_sel = '0;
      fwd_we  = 1'b0;
      fwd_cyc = 1'b0;
      fwd_stb = 1'b0;
      fwd_cti = '0;
      fwd_bte = '0;
      if (owned) begin
         fwd_adr = bus.wbm_adr_i[last];
         fwd_dat = bus.wbm_dat_i[last];
         fwd_sel = bus.wbm_sel_i[last];
         fwd_we  = bus.wbm_we_i[last];
         fwd_cyc = owner_cyc & ~tout;
         fwd_stb = owner_cyc & bus.wbm_stb_i[last] & ~tout;
         fwd_cti = bus.wbm_cti_i[last];
         fwd_bte = bus.wbm_bte_i[last];
      end
   end

   assign bus.wbs_adr_o = fwd_adr;
   assign bus.wbs_dat_o = fwd_dat;
   assign bus.wbs_sel_o = fwd_sel;
   assign bus.wbs_we_o  = fwd_we;
   assign bus.wbs_cyc_o = fwd_cyc;
   assign bus.wbs_stb_o = fwd_stb;
   assign bus.wbs_cti_o = fwd_cti;
   assign bus.wbs_bte_o = fwd_bte;

   assign bus.wbm_dat_o = {NUM_MASTERS{bus.wbs_dat_i}};
   assign bus.wbm_ack_o = grant & {NUM_MASTERS{bus.wbs_ack_i}};
   assign bus.wbm_rty_o = grant & {NUM_MASTERS{bus.wbs_rty_i}};
   assign bus.wbm_err_o = grant & {NUM_MASTERS{bus.wbs_err_i | tout}};
   assign bus.grant_o   = grant;
endmodule

// File: tb/tb_peripheral_msi_arbiter_wb.sv
// Directed bench for the round-robin Wishbone arbiter: a two-master instance
// with a short watchdog and a three-master instance for rotation order.
module tb_peripheral_msi_arbiter_wb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h2000_0000;
   localparam logic [31:0] D1 = 32'hBEEF_0001;

   always #5 clk = ~clk;

   peripheral_msi_arbiter_wb_if #(.DW(32), .AW(32), .NUM_MASTERS(2)) bus2 ();
   peripheral_msi_arbiter_wb_if #(.DW(32), .AW(32), .NUM_MASTERS(3)) bus3 ();

   peripheral_msi_arbiter_wb #(.DW(32), .AW(32), .NUM_MASTERS(2), .TIMEOUT(8)) u_dut2 (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus2)
   );

   peripheral_msi_arbiter_wb #(.DW(32), .AW(32), .NUM_MASTERS(3), .TIMEOUT(255)) u_dut3 (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus3)
   );

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs;
      bus2.wbm_adr_i = '0; bus2.wbm_dat_i = '0; bus2.wbm_sel_i = '0;
      bus2.wbm_we_i  = '0; bus2.wbm_cyc_i = '0; bus2.wbm_stb_i = '0;
      bus2.wbm_cti_i = '0; bus2.wbm_bte_i = '0;
      bus2.wbs_dat_i = '0; bus2.wbs_ack_i = 1'b0; bus2.wbs_err_i = 1'b0; bus2.wbs_rty_i = 1'b0;
      bus3.wbm_adr_i = '0; bus3.wbm_dat_i = '0; bus3.wbm_sel_i = '0;
      bus3.wbm_we_i  = '0; bus3.wbm_cyc_i = '0; bus3.wbm_stb_i = '0;
      bus3.wbm_cti_i = '0; bus3.wbm_bte_i = '0;
      bus3.wbs_dat_i = '0; bus3.wbs_ack_i = 1'b0; bus3.wbs_err_i = 1'b0; bus3.wbs_rty_i = 1'b0;
   endtask

   // Both masters request during reset; master 0 must win first.
   task automatic test_reset;
      bus2.wbm_adr_i[0] = A0;
      bus2.wbm_adr_i[1] = A1;
      bus2.wbm_cyc_i    = 2'b11;
      bus2.wbm_stb_i    = 2'b11;
      bus2.wbs_ack_i    = 1'b1;
      next_cycle; #1;
      checks++; if (bus2.grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", bus2.grant_o); end
      checks++; if (bus2.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b exp 0", bus2.wbs_cyc_o); end
      checks++; if (bus2.wbs_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", bus2.wbs_adr_o); end
      checks++; if (bus2.wbm_ack_o !== 2'b00) begin errors++; $display("FAIL reset_ack got %b exp 00", bus2.wbm_ack_o); end
      bus2.wbs_ack_i = 1'b0;
      rst = 1'b0;
      next_cycle; #1;
      checks++; if (bus2.grant_o !== 2'b01) begin errors++; $display("FAIL first_grant got %b exp 01", bus2.grant_o); end
      checks++; if (bus2.wbs_adr_o !== A0) begin errors++; $display("FAIL first_adr got %h exp %h", bus2.wbs_adr_o, A0); end
      checks++; if (bus2.wbs_cyc_o !== 1'b1) begin errors++; $display("FAIL first_cyc got %b exp 1", bus2.wbs_cyc_o); end
      bus2.wbs_ack_i = 1'b1;
      #1;
      checks++; if (bus2.wbm_ack_o !== 2'b01) begin errors++; $display("FAIL first_ack got %b exp 01", bus2.wbm_ack_o); end
      bus2.wbs_ack_i = 1'b0;
      bus2.wbm_cyc_i = 2'b00;
      bus2.wbm_stb_i = 2'b00;
      next_cycle; #1;
      checks++; if (bus2.grant_o !== 2'b00) begin errors++; $display("FAIL release_idle got %b exp 00", bus2.grant_o); end
   endtask

   // Master 0 holds through 4 acked transfers while master 1 waits.
   task automatic test_hold;
      bus2.wbm_cyc_i = 2'b01;
      bus2.wbm_stb_i = 2'b01;
      next_cycle;
      bus2.wbm_cyc_i = 2'b11;
      bus2.wbm_stb_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
         bus2.wbs_ack_i = 1'b1;
         #1;
         checks++; if (bus2.grant_o !== 2'b01) begin errors++; $display("FAIL hold_grant[%0d] got %b exp 01", k, bus2.grant_o); end
         checks++; if (bus2.wbm_ack_o !== 2'b01) begin errors++; $display("FAIL hold_ack[%0d] got %b exp 01", k, bus2.wbm_ack_o); end
         next_cycle;
      end
      bus2.wbs_ack_i = 1'b0;
      bus2.wbm_cyc_i = 2'b10;
      bus2.wbm_stb_i = 2'b10;
      #1;
      checks++; if (bus2.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL handover_gap got %b exp 0", bus2.wbs_cyc_o); end
      checks++; if (bus2.grant_o !== 2'b01) begin errors++; $display("FAIL handover_old got %b exp 01", bus2.grant_o); end
      next_cycle; #1;
      checks++; if (bus2.grant_o !== 2'b10) begin errors++; $display("FAIL handover_new got %b exp 10", bus2.grant_o); end
      checks++; if (bus2.wbs_cyc_o !== 1'b1) begin errors++; $display("FAIL handover_cyc got %b exp 1", bus2.wbs_cyc_o); end
      checks++; if (bus2.wbs_adr_o !== A1) begin errors++; $display("FAIL handover_adr got %h exp %h", bus2.wbs_adr_o, A1); end
      bus2.wbm_cyc_i = 2'b00;
      bus2.wbm_stb_i = 2'b00;
      next_cycle; #1;
      checks++; if (bus2.grant_o !== 2'b00) begin errors++; $display("FAIL hold_idle got %b exp 00", bus2.grant_o); end
   endtask

   // Incrementing 4-beat burst from master 1 with master 0 pending.
   task automatic test_burst;
      logic [31:0] exp_adr;
      logic [2:0]  exp_cti;
      logic [31:0] rdat;
      bus2.wbm_cti_i[0] = 3'b000;
      bus2.wbm_bte_i[0] = 2'b10;
      bus2.wbm_cti_i[1] = 3'b010;
      bus2.wbm_bte_i[1] = 2'b01;
      bus2.wbm_we_i     = 2'b10;
      bus2.wbm_dat_i[1] = D1;
      bus2.wbm_cyc_i    = 2'b10;
      bus2.wbm_stb_i    = 2'b10;
      next_cycle;
      bus2.wbm_cyc_i = 2'b11;
      bus2.wbm_stb_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_adr = A1 + 32'(4 * k);
         exp_cti = (k == 3) ? 3'b111 : 3'b010;
         rdat    = 32'hC0DE_0000 + 32'(k);
         bus2.wbm_adr_i[1] = exp_adr;
         bus2.wbm_cti_i[1] = exp_cti;
         bus2.wbs_dat_i    = rdat;
         bus2.wbs_ack_i    = 1'b1;
         #1;
         checks++; if (bus2.grant_o !== 2'b10) begin errors++; $display("FAIL burst_grant[%0d] got %b exp 10", k, bus2.grant_o); end
         checks++; if (bus2.wbs_cti_o !== exp_cti) begin errors++; $display("FAIL burst_cti[%0d] got %b exp %b", k, bus2.wbs_cti_o, exp_cti); end
         checks++; if (bus2.wbs_bte_o !== 2'b01) begin errors++; $display("FAIL burst_bte[%0d] got %b exp 01", k, bus2.wbs_bte_o); end
         checks++; if (bus2.wbs_adr_o !== exp_adr) begin errors++; $display("FAIL burst_adr[%0d] got %h exp %h", k, bus2.wbs_adr_o, exp_adr); end
         checks++; if (bus2.wbm_ack_o !== 2'b10) begin errors++; $display("FAIL burst_ack[%0d] got %b exp 10", k, bus2.wbm_ack_o); end
         next_cycle;
      end
      checks++; if (bus2.wbm_dat_o[0] !== 32'hC0DE_0003) begin errors++; $display("FAIL bcast_dat0 got %h exp c0de0003", bus2.wbm_dat_o[0]); end
      checks++; if (bus2.wbs_dat_o !== D1) begin errors++; $display("FAIL burst_wdat got %h exp %h", bus2.wbs_dat_o, D1); end
      checks++; if (bus2.wbs_we_o !== 1'b1) begin errors++; $display("FAIL burst_we got %b exp 1", bus2.wbs_we_o); end
      bus2.wbs_ack_i = 1'b0;
      bus2.wbm_cyc_i = 2'b01;
      bus2.wbm_stb_i = 2'b01;
      #1;
      checks++; if (bus2.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL burst_gap got %b exp 0", bus2.wbs_cyc_o); end
      next_cycle; #1;
      checks++; if (bus2.grant_o !== 2'b01) begin errors++; $display("FAIL burst_next got %b exp 01", bus2.grant_o); end
      checks++; if (bus2.wbs_bte_o !== 2'b10) begin errors++; $display("FAIL burst_next_bte got %b exp 10", bus2.wbs_bte_o); end
      checks++; if (bus2.wbs_we_o !== 1'b0) begin errors++; $display("FAIL burst_next_we got %b exp 0", bus2.wbs_we_o); end
      bus2.wbm_cyc_i = 2'b00;
      bus2.wbm_stb_i = 2'b00;
      next_cycle;
   endtask

   // Silent slave with TIMEOUT=8: error after 8 strobes, restart, late ack wins.
   task automatic test_timeout;
      bus2.wbm_cyc_i = 2'b01;
      bus2.wbm_stb_i = 2'b01;
      next_cycle;
      for (int rep = 0; rep < 2; rep++) begin
         for (int k = 1; k <= 8; k++) begin
            #1;
            checks++; if (bus2.wbm_err_o !== 2'b00) begin errors++; $display("FAIL wd_early[%0d.%0d] got %b exp 00", rep, k, bus2.wbm_err_o); end
            checks++; if (bus2.wbs_stb_o !== 1'b1) begin errors++; $display("FAIL wd_stb[%0d.%0d] got %b exp 1", rep, k, bus2.wbs_stb_o); end
            next_cycle;
         end
         #1;
         checks++; if (bus2.wbm_err_o !== 2'b01) begin errors++; $display("FAIL wd_err[%0d] got %b exp 01", rep, bus2.wbm_err_o); end
         checks++; if (bus2.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL wd_cyc[%0d] got %b exp 0", rep, bus2.wbs_cyc_o); end
         checks++; if (bus2.grant_o !== 2'b01) begin errors++; $display("FAIL wd_grant[%0d] got %b exp 01", rep, bus2.grant_o); end
         next_cycle;
      end
      for (int k = 1; k <= 7; k++) begin
         #1;
         checks++; if (bus2.wbm_err_o !== 2'b00) begin errors++; $display("FAIL wd_pre_ack[%0d] got %b exp 00", k, bus2.wbm_err_o); end
         next_cycle;
      end
      bus2.wbs_ack_i = 1'b1;
      next_cycle;
      bus2.wbs_ack_i = 1'b0;
      #1;
      checks++; if (bus2.wbm_err_o !== 2'b00) begin errors++; $display("FAIL wd_ack_wins got %b exp 00", bus2.wbm_err_o); end
      checks++; if (bus2.wbs_stb_o !== 1'b1) begin errors++; $display("FAIL wd_ack_stb got %b exp 1", bus2.wbs_stb_o); end
      bus2.wbm_cyc_i = 2'b00;
      bus2.wbm_stb_i = 2'b00;
      next_cycle;
   endtask

   // Reset mid-transfer drops the bus at once; master 0 wins again afterwards.
   task automatic test_reset_mid;
      bus2.wbm_cyc_i = 2'b01;
      bus2.wbm_stb_i = 2'b01;
      next_cycle; #1;
      checks++; if (bus2.wbs_cyc_o !== 1'b1) begin errors++; $display("FAIL mid_pre_cyc got %b exp 1", bus2.wbs_cyc_o); end
      bus2.wbs_ack_i = 1'b1;
      rst = 1'b1;
      #1;
      checks++; if (bus2.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL mid_cyc got %b exp 0", bus2.wbs_cyc_o); end
      checks++; if (bus2.grant_o !== 2'b00) begin errors++; $display("FAIL mid_grant got %b exp 00", bus2.grant_o); end
      checks++; if (bus2.wbm_ack_o !== 2'b00) begin errors++; $display("FAIL mid_ack got %b exp 00", bus2.wbm_ack_o); end
      checks++; if (bus2.wbm_err_o !== 2'b00) begin errors++; $display("FAIL mid_err got %b exp 00", bus2.wbm_err_o); end
      next_cycle;
      bus2.wbs_ack_i = 1'b0;
      bus2.wbm_cyc_i = 2'b11;
      bus2.wbm_stb_i = 2'b11;
      rst = 1'b0;
      #1;
      checks++; if (bus2.grant_o !== 2'b00) begin errors++; $display("FAIL mid_post_idle got %b exp 00", bus2.grant_o); end
      next_cycle; #1;
      checks++; if (bus2.grant_o !== 2'b01) begin errors++; $display("FAIL mid_restart got %b exp 01", bus2.grant_o); end
      checks++; if (bus2.wbs_adr_o !== A0) begin errors++; $display("FAIL mid_restart_adr got %h exp %h", bus2.wbs_adr_o, A0); end
      bus2.wbm_cyc_i = 2'b00;
      bus2.wbm_stb_i = 2'b00;
      next_cycle;
   endtask

   // Three masters all requesting, each releasing after one ack: 0,1,2,0,1.
   task automatic test_rr3;
      logic [2:0] exp_g;
      bus3.wbm_cyc_i = 3'b111;
      bus3.wbm_stb_i = 3'b111;
      next_cycle;
      for (int k = 0; k < 5; k++) begin
         exp_g = 3'(1 << (k % 3));
         #1;
         checks++; if (bus3.grant_o !== exp_g) begin errors++; $display("FAIL rr3_grant[%0d] got %b exp %b", k, bus3.grant_o, exp_g); end
         bus3.wbs_ack_i = 1'b1;
         #1;
         checks++; if (bus3.wbm_ack_o !== exp_g) begin errors++; $display("FAIL rr3_ack[%0d] got %b exp %b", k, bus3.wbm_ack_o, exp_g); end
         next_cycle;
         bus3.wbs_ack_i = 1'b0;
         bus3.wbm_cyc_i = 3'b111 & ~exp_g;
         bus3.wbm_stb_i = 3'b111 & ~exp_g;
         #1;
         checks++; if (bus3.wbs_cyc_o !== 1'b0) begin errors++; $display("FAIL rr3_gap[%0d] got %b exp 0", k, bus3.wbs_cyc_o); end
         next_cycle;
         bus3.wbm_cyc_i = 3'b111;
         bus3.wbm_stb_i = 3'b111;
      end
      bus3.wbm_cyc_i = 3'b000;
      bus3.wbm_stb_i = 3'b000;
      next_cycle;
   endtask

   initial begin
      init_inputs();
      test_reset();
      test_hold();
      test_burst();
      test_timeout();
      test_reset_mid();
      test_rr3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
